// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_sequencer_pkg;

    localparam int ADDR_W     = 16;
    localparam int INSTR_W    = 32;
    localparam int FIFO_DEPTH = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        HALT  = 2'd3
    } fetch_state_e;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        if (value == 32'hFFFF_FFFF) begin
            return value;
        end else begin
            return value + 32'd1;
        end
    endfunction

endpackage

// File: rtl/fetch_sequencer_fifo.sv
// fetch_fifo: two-entry {instr, pc} buffer; the head is held in its own register
// so the fetch outputs come straight from flops.
module fetch_fifo #(
    parameter int WIDTH = 48
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] head_r;
    logic [WIDTH-1:0] tail_r;
    logic             head_vld_r;
    logic             tail_vld_r;
    logic             pop_s;

    assign pop_s = pop & head_vld_r;

    // Entry storage: tail shifts into head on pop; flush only clears the valid bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_r     <= '0;
            tail_r     <= '0;
            head_vld_r <= 1'b0;
            tail_vld_r <= 1'b0;
        end else if (flush) begin
            head_vld_r <= 1'b0;
            tail_vld_r <= 1'b0;
        end else begin
            case ({push, pop_s})
                2'b11: begin
                    if (tail_vld_r) begin
                        head_r <= tail_r;
                        tail_r <= din;
                    end else begin
                        head_r <= din;
                    end
                end
                2'b10: begin
                    if (!head_vld_r) begin
                        head_r     <= din;
                        head_vld_r <= 1'b1;
                    end else if (!tail_vld_r) begin
                        tail_r     <= din;
                        tail_vld_r <= 1'b1;
                    end else begin
                        tail_r <= tail_r;
                    end
                end
                2'b01: begin
                    head_r     <= tail_r;
                    head_vld_r <= tail_vld_r;
                    tail_vld_r <= 1'b0;
                end
                default: begin
                    head_vld_r <= head_vld_r;
                end
            endcase
        end
    end

    assign dout  = head_r;
    assign valid = head_vld_r;
    assign full  = tail_vld_r;
    assign empty = ~head_vld_r;

endmodule

// File: rtl/fetch_sequencer.sv
// Sequential instruction fetch with branch redirect and a 2-deep output buffer.
// Optional performance counters are enabled with the FETCH_SEQ_PERF_EN macro.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000,
    parameter logic [ADDR_W-1:0] PROG_LEN = 16'd7
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [INSTR_W-1:0] rom_data,
    output logic               if_valid,
    input  logic               if_ready,
    output logic [INSTR_W-1:0] if_instr,
    output logic [ADDR_W-1:0]  if_pc,
    input  logic               br_taken,
    input  logic [ADDR_W-1:0]  br_target,
    output logic               halt
`ifdef FETCH_SEQ_PERF_EN
    ,
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_stall
`endif
);

    fetch_state_e                state_r;
    fetch_state_e                state_next_s;
    fetch_state_e                br_dest_s;
    logic [ADDR_W-1:0]           pc_r;
    logic [ADDR_W-1:0]           pc_next_s;
    logic                        halt_r;
    logic                        halt_next_s;
    logic                        br_act_s;
    logic                        push_s;
    logic                        pop_s;
    logic                        fifo_valid_s;
    logic                        fifo_full_s;
    logic                        fifo_empty_s;
    logic [INSTR_W+ADDR_W-1:0]   fifo_dout_s;

    // A redirect is ignored in IDLE, where the buffer is already empty.
    assign br_act_s  = br_taken && (state_r != IDLE);
    assign br_dest_s = (br_target >= PROG_LEN) ? DRAIN : RUN;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; a redirect overrides every other transition.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                state_next_s = RUN;
            end
            RUN: begin
                if (br_act_s) begin
                    state_next_s = br_dest_s;
                end else if (pc_r >= PROG_LEN) begin
                    state_next_s = DRAIN;
                end else begin
                    state_next_s = RUN;
                end
            end
            DRAIN: begin
                if (br_act_s) begin
                    state_next_s = br_dest_s;
                end else if (fifo_empty_s) begin
                    state_next_s = HALT;
                end else begin
                    state_next_s = DRAIN;
                end
            end
            HALT: begin
                if (br_act_s) begin
                    state_next_s = br_dest_s;
                end else begin
                    state_next_s = HALT;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Fetch control; a same-cycle pop frees a slot for the push.
    always_comb begin
        pop_s       = 1'b0;
        push_s      = 1'b0;
        pc_next_s   = pc_r;
        halt_next_s = (state_next_s == HALT);
        if (br_act_s) begin
            pc_next_s = br_target;
        end else begin
            pop_s  = fifo_valid_s && if_ready;
            push_s = (state_r == RUN) && (pc_r < PROG_LEN) && (!fifo_full_s || pop_s);
            if (push_s) begin
                pc_next_s = pc_r + 16'd1;
            end else begin
                pc_next_s = pc_r;
            end
        end
    end

    // Program counter and halt flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r   <= RESET_PC;
            halt_r <= 1'b0;
        end else begin
            pc_r   <= pc_next_s;
            halt_r <= halt_next_s;
        end
    end

    fetch_fifo #(
        .WIDTH(INSTR_W + ADDR_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s),
        .pop   (pop_s),
        .flush (br_act_s),
        .din   ({rom_data, pc_r}),
        .dout  (fifo_dout_s),
        .valid (fifo_valid_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    assign rom_addr = pc_r;
    assign if_valid = fifo_valid_s;
    assign if_instr = fifo_dout_s[INSTR_W+ADDR_W-1:ADDR_W];
    assign if_pc    = fifo_dout_s[ADDR_W-1:0];
    assign halt     = halt_r;

`ifdef FETCH_SEQ_PERF_EN
    logic [31:0] perf_fetched_r;
    logic [31:0] perf_stall_r;

    // Saturating event counters; survive redirects, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched_r <= 32'd0;
            perf_stall_r   <= 32'd0;
        end else begin
            if (push_s) begin
                perf_fetched_r <= sat_inc(perf_fetched_r);
            end else begin
                perf_fetched_r <= perf_fetched_r;
            end
            if (fifo_valid_s && !if_ready) begin
                perf_stall_r <= sat_inc(perf_stall_r);
            end else begin
                perf_stall_r <= perf_stall_r;
            end
        end
    end

    assign perf_fetched = perf_fetched_r;
    assign perf_stall   = perf_stall_r;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: expected pcs are queued by the stimulus,
// and a negedge monitor checks every accepted fetch against the queue head.
module tb_fetch_sequencer;

    logic        clk;
    logic        rst_n;
    logic [15:0] rom_addr;
    logic [31:0] rom_data;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [15:0] if_pc;
    logic        br_taken;
    logic [15:0] br_target;
    logic        halt;
`ifdef FETCH_SEQ_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
`endif

    int          n_vec  = 0;
    int          n_miss = 0;
    logic [15:0] exp_q[$];

    function automatic logic [31:0] rom_word(input logic [15:0] a);
        return {a ^ 16'hA5C3, ~a};
    endfunction

    assign rom_data = rom_word(rom_addr);

    fetch_sequencer #(
        .RESET_PC(16'h0000),
        .PROG_LEN(16'd7)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .if_valid  (if_valid),
        .if_ready  (if_ready),
        .if_instr  (if_instr),
        .if_pc     (if_pc),
        .br_taken  (br_taken),
        .br_target (br_target),
        .halt      (halt)
`ifdef FETCH_SEQ_PERF_EN
        ,
        .perf_fetched (perf_fetched),
        .perf_stall   (perf_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_range(input int lo, input int hi);
        for (int a = lo; a <= hi; a++) exp_q.push_back(16'(a));
    endtask

    task automatic wait_halt(input int budget);
        for (int i = 0; i < budget && !halt; i++) step();
        chk("halt_reached", 32'(halt), 32'd1);
    endtask

    task automatic branch(input logic [15:0] tgt);
        br_taken  = 1'b1;
        br_target = tgt;
        step();
        br_taken  = 1'b0;
    endtask

    // Monitor: every accepted head entry must match the next queued pc.
    always @(negedge clk) begin
        if (rst_n && if_valid && if_ready && !br_taken) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected_fetch: got pc %h, expected none", if_pc);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                chk("deliver_pc", 32'(if_pc), 32'(e));
                chk("deliver_instr", if_instr, rom_word(e));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        if_ready  = 1'b1;
        br_taken  = 1'b0;
        br_target = 16'h0000;
        #2;
        chk("rst_valid", 32'(if_valid), 32'd0);
        chk("rst_halt", 32'(halt), 32'd0);
        chk("rst_instr", if_instr, 32'd0);
        chk("rst_pc", 32'(if_pc), 32'd0);
        chk("rst_rom_addr", 32'(rom_addr), 32'h0000);

        // Straight-line run of the 7-word program.
        @(negedge clk);
        rst_n = 1'b1;
        push_range(0, 6);
        step();
        chk("lat_edge1_valid", 32'(if_valid), 32'd0);
        step();
        chk("lat_edge2_valid", 32'(if_valid), 32'd1);
        chk("lat_edge2_pc", 32'(if_pc), 32'd0);
        repeat (7) step();
        chk("drain_valid", 32'(if_valid), 32'd0);
        chk("drain_halt", 32'(halt), 32'd0);
        chk("drain_queue", 32'(exp_q.size()), 32'd0);
        step();
        chk("halt_timing", 32'(halt), 32'd1);
`ifdef FETCH_SEQ_PERF_EN
        chk("perf_fetched_run", perf_fetched, 32'd7);
        chk("perf_stall_run", perf_stall, 32'd0);
`endif

        // Branch out of HALT, then backpressure from the third cycle.
        push_range(0, 6);
        branch(16'h0000);
        chk("rehalt_drop", 32'(halt), 32'd0);
        chk("rebr_valid", 32'(if_valid), 32'd0);
        step();
        step();
        if_ready = 1'b0;
        repeat (3) step();
        chk("bp_pc_frozen", 32'(rom_addr), 32'd3);
        chk("bp_head_pc", 32'(if_pc), 32'd1);
        chk("bp_head_instr", if_instr, rom_word(16'h0001));
        chk("bp_valid", 32'(if_valid), 32'd1);
`ifdef FETCH_SEQ_PERF_EN
        chk("perf_stall_bp", perf_stall, 32'd3);
`endif
        if_ready = 1'b1;
        wait_halt(40);
        chk("bp_queue", 32'(exp_q.size()), 32'd0);

        // Flush of two buffered entries by a branch to address 1.
        if_ready = 1'b0;
        branch(16'h0000);
        repeat (3) step();
        chk("fl_head_pc", 32'(if_pc), 32'd0);
        chk("fl_rom_addr", 32'(rom_addr), 32'd2);
        push_range(1, 6);
        if_ready = 1'b1;
        branch(16'h0001);
        chk("fl_valid", 32'(if_valid), 32'd0);
        chk("fl_pc", 32'(rom_addr), 32'd1);
        wait_halt(40);
        chk("fl_queue", 32'(exp_q.size()), 32'd0);

        // Branch past the end of the program with a full buffer.
        if_ready = 1'b0;
        branch(16'h0000);
        repeat (3) step();
        chk("far_pre_valid", 32'(if_valid), 32'd1);
        branch(16'h0009);
        chk("far_valid", 32'(if_valid), 32'd0);
        chk("far_halt_pending", 32'(halt), 32'd0);
        step();
        chk("far_halt", 32'(halt), 32'd1);
        if_ready = 1'b1;
        repeat (3) step();
        chk("far_idle_valid", 32'(if_valid), 32'd0);
        chk("far_idle_halt", 32'(halt), 32'd1);

        // Asynchronous reset with two entries buffered.
        if_ready = 1'b0;
        branch(16'h0000);
        repeat (3) step();
        chk("mid_pre_valid", 32'(if_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(if_valid), 32'd0);
        chk("mid_rst_rom_addr", 32'(rom_addr), 32'h0000);
        chk("mid_rst_halt", 32'(halt), 32'd0);
`ifdef FETCH_SEQ_PERF_EN
        chk("mid_rst_perf", perf_fetched, 32'd0);
`endif
        @(negedge clk);
        rst_n    = 1'b1;
        if_ready = 1'b1;
        push_range(0, 6);
        step();
        chk("restart_edge1_valid", 32'(if_valid), 32'd0);
        step();
        chk("restart_pc", 32'(if_pc), 32'd0);
        wait_halt(40);
        chk("restart_queue", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
